// File: rtl/lr_sc_resv_unit.sv
// LR/SC reservation table: one reservation per hart ID, invalidated by SC,
// snooped stores from other IDs, explicit clears and an optional lifetime.
`ifndef XLEN
`define XLEN 32
`endif

module lr_sc_resv_unit #(
  parameter int ADDR_WIDTH   = `XLEN,
  parameter int N_IDS        = 2,
  parameter int GRANULE_LOG2 = 2,
  parameter int TIMEOUT      = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_lr,
  input  logic                     i_sc,
  input  logic [$clog2(N_IDS)-1:0] i_id,
  input  logic [ADDR_WIDTH-1:0]    i_addr,
  input  logic                     i_wr_en,
  input  logic [$clog2(N_IDS)-1:0] i_wr_id,
  input  logic [ADDR_WIDTH-1:0]    i_wr_addr,
  input  logic                     i_clr_en,
  input  logic [$clog2(N_IDS)-1:0] i_clr_id,
  output logic                     o_gnt,
  output logic [N_IDS-1:0]         o_resv_vld
);

  localparam int IDW = $clog2(N_IDS);
  localparam int GW  = ADDR_WIDTH - GRANULE_LOG2;
  localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT);

  logic [N_IDS-1:0] vld_q, vld_d;
  logic [GW-1:0]    gran_q [N_IDS];
  logic [GW-1:0]    gran_d [N_IDS];
  logic [CW-1:0]    cnt_q  [N_IDS];
  logic [CW-1:0]    cnt_d  [N_IDS];

  logic [GW-1:0]    req_gran, wr_gran;
  logic [N_IDS-1:0] hit_req, hit_wr, kill, expire;
  logic             sc_only, wr_conflict;

  assign req_gran = i_addr[ADDR_WIDTH-1:GRANULE_LOG2];
  assign wr_gran  = i_wr_addr[ADDR_WIDTH-1:GRANULE_LOG2];

  generate
    if (GRANULE_LOG2 > 0) begin : g_lsb
      logic unused_lsbs;
      assign unused_lsbs = ^{i_addr[GRANULE_LOG2-1:0], i_wr_addr[GRANULE_LOG2-1:0]};
    end
  endgenerate

  always_comb begin
    hit_req = '0;
    hit_wr  = '0;
    for (int k = 0; k < N_IDS; k++) begin
      hit_req[k] = vld_q[k] && (gran_q[k] == req_gran);
      hit_wr[k]  = vld_q[k] && (gran_q[k] == wr_gran);
    end
  end

  // A same-cycle store from another ID is ordered ahead of the SC and breaks it.
  assign sc_only     = i_sc && !i_lr;
  assign wr_conflict = i_wr_en && (i_wr_id != i_id) && (wr_gran == req_gran);
  assign o_gnt       = sc_only && hit_req[i_id] && !wr_conflict;

  always_comb begin
    kill   = '0;
    expire = '0;
    for (int k = 0; k < N_IDS; k++) begin
      expire[k] = (TIMEOUT > 0) && vld_q[k] && (cnt_q[k] == CW'(1));
      kill[k]   = (sc_only && (i_id == IDW'(k)))
               || (i_wr_en && (i_wr_id != IDW'(k)) && hit_wr[k])
               || (o_gnt && (i_id != IDW'(k)) && hit_req[k])
               || expire[k];
    end
  end

  // Priority per entry: clear, then LR (wins over stores/expiry), then kills.
  always_comb begin
    vld_d = vld_q;
    for (int k = 0; k < N_IDS; k++) begin
      gran_d[k] = gran_q[k];
      cnt_d[k]  = cnt_q[k];
    end
    for (int k = 0; k < N_IDS; k++) begin
      if (i_clr_en && (i_clr_id == IDW'(k))) begin
        vld_d[k] = 1'b0;
        cnt_d[k] = '0;
      end else if (i_lr && (i_id == IDW'(k))) begin
        vld_d[k]  = 1'b1;
        gran_d[k] = req_gran;
        cnt_d[k]  = CNT_LOAD;
      end else if (kill[k]) begin
        vld_d[k] = 1'b0;
        cnt_d[k] = '0;
      end else if (vld_q[k] && (TIMEOUT > 0)) begin
        cnt_d[k] = cnt_q[k] - CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      vld_q <= '0;
      for (int k = 0; k < N_IDS; k++) begin
        gran_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < N_IDS; k++) begin
        gran_q[k] <= gran_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
    end
  end

  assign o_resv_vld = vld_q;

endmodule

// File: tb/tb_lr_sc_resv_unit.sv
// Bench for lr_sc_resv_unit: two instances (lifetime 64 and 4) share stimulus and
// are compared every cycle against a deadline-based reservation model.
module tb_lr_sc_resv_unit;

  logic        clk;
  logic        i_rst;
  logic        i_lr, i_sc, i_wr_en, i_clr_en;
  logic [0:0]  i_id, i_wr_id, i_clr_id;
  logic [31:0] i_addr, i_wr_addr;
  logic        gnt64, gnt4;
  logic [1:0]  vld64, vld4;

  int n_vec = 0;
  int n_err = 0;

  lr_sc_resv_unit #(.ADDR_WIDTH(32), .N_IDS(2), .GRANULE_LOG2(2), .TIMEOUT(64)) u_dut64 (
    .i_clk(clk), .i_rst(i_rst), .i_lr(i_lr), .i_sc(i_sc), .i_id(i_id), .i_addr(i_addr),
    .i_wr_en(i_wr_en), .i_wr_id(i_wr_id), .i_wr_addr(i_wr_addr),
    .i_clr_en(i_clr_en), .i_clr_id(i_clr_id), .o_gnt(gnt64), .o_resv_vld(vld64));

  lr_sc_resv_unit #(.ADDR_WIDTH(32), .N_IDS(2), .GRANULE_LOG2(2), .TIMEOUT(4)) u_dut4 (
    .i_clk(clk), .i_rst(i_rst), .i_lr(i_lr), .i_sc(i_sc), .i_id(i_id), .i_addr(i_addr),
    .i_wr_en(i_wr_en), .i_wr_id(i_wr_id), .i_wr_addr(i_wr_addr),
    .i_clr_en(i_clr_en), .i_clr_id(i_clr_id), .o_gnt(gnt4), .o_resv_vld(vld4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a reservation taken by an LR in cycle c is live through cycle c+lifetime.
  int          life [2] = '{64, 4};
  bit          m_v  [2][2];
  logic [29:0] m_g  [2][2];
  int          m_dl [2][2];
  int          cyc = 0;

  function automatic bit live(int d, int k);
    return m_v[d][k] && (life[d] == 0 || cyc <= m_dl[d][k]);
  endfunction

  function automatic bit exp_gnt(int d);
    bit conflict;
    conflict = i_wr_en && (i_wr_id != i_id) && (i_wr_addr[31:2] == i_addr[31:2]);
    return i_sc && !i_lr && live(d, int'(i_id)) && (m_g[d][i_id] == i_addr[31:2]) && !conflict;
  endfunction

  function automatic logic [1:0] exp_vld(int d);
    return {live(d, 1), live(d, 0)};
  endfunction

  function automatic bit next_v(int d, int k);
    if (i_clr_en && int'(i_clr_id) == k) return 1'b0;
    if (i_lr && int'(i_id) == k) return 1'b1;
    if (i_sc && int'(i_id) == k) return 1'b0;
    if (i_wr_en && int'(i_wr_id) != k && m_g[d][k] == i_wr_addr[31:2]) return 1'b0;
    if (exp_gnt(d) && int'(i_id) != k && m_g[d][k] == i_addr[31:2]) return 1'b0;
    return live(d, k);
  endfunction

  always @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int d = 0; d < 2; d++)
        for (int k = 0; k < 2; k++) begin
          m_v[d][k]  <= 1'b0;
          m_g[d][k]  <= '0;
          m_dl[d][k] <= 0;
        end
    end else begin
      for (int d = 0; d < 2; d++)
        for (int k = 0; k < 2; k++) begin
          m_v[d][k] <= next_v(d, k);
          if (i_lr && int'(i_id) == k && !(i_clr_en && int'(i_clr_id) == k)) begin
            m_g[d][k]  <= i_addr[31:2];
            m_dl[d][k] <= cyc + life[d];
          end
        end
      cyc <= cyc + 1;
    end
  end

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (i_rst === 1'b1) begin
      check("model_gnt64", {31'd0, gnt64}, {31'd0, exp_gnt(0)});
      check("model_gnt4",  {31'd0, gnt4},  {31'd0, exp_gnt(1)});
      check("model_vld64", {30'd0, vld64}, {30'd0, exp_vld(0)});
      check("model_vld4",  {30'd0, vld4},  {30'd0, exp_vld(1)});
    end
  end

  task automatic idle();
    i_lr = 0; i_sc = 0; i_wr_en = 0; i_clr_en = 0;
  endtask
  task automatic nxt();
    @(posedge clk); #1; idle();
  endtask
  task automatic run(int n);
    repeat (n) begin @(negedge clk); nxt(); end
  endtask
  task automatic do_lr(bit id, logic [31:0] a);
    i_lr = 1; i_id = id; i_addr = a;
  endtask
  task automatic do_sc(bit id, logic [31:0] a);
    i_sc = 1; i_id = id; i_addr = a;
  endtask
  task automatic do_wr(bit id, logic [31:0] a);
    i_wr_en = 1; i_wr_id = id; i_wr_addr = a;
  endtask

  logic [31:0] pool [4] = '{32'h100, 32'h101, 32'h104, 32'h200};

  initial begin
    idle();
    i_id = 0; i_addr = 0; i_wr_id = 0; i_wr_addr = 0; i_clr_id = 0;
    i_rst = 0;
    @(negedge clk);
    check("reset_vld64", {30'd0, vld64}, 32'd0);
    check("reset_gnt64", {31'd0, gnt64}, 32'd0);
    @(posedge clk); #1;
    i_rst = 1;

    // LR then SC to the same granule with a different byte offset
    do_lr(0, 32'h1000); run(1);
    run(5);
    do_sc(0, 32'h1003); @(negedge clk);
    check("sc_same_granule", {31'd0, gnt64}, 32'd1); nxt();
    @(negedge clk); check("sc_clears_own", {30'd0, vld64}, 32'd0); nxt();

    // Successful SC by id1 kills id0's reservation to the same granule
    do_lr(0, 32'h1000); run(1);
    do_lr(1, 32'h1000); run(1);
    do_sc(1, 32'h1000); @(negedge clk);
    check("sc_id1_ok", {31'd0, gnt64}, 32'd1); nxt();
    do_sc(0, 32'h1000); @(negedge clk);
    check("sc_id0_killed", {31'd0, gnt64}, 32'd0); nxt();

    // Same-cycle foreign store wins over SC; own store does not break reservation
    do_lr(1, 32'h2000); run(1);
    do_sc(1, 32'h2000); do_wr(0, 32'h2002); @(negedge clk);
    check("sc_vs_store", {31'd0, gnt64}, 32'd0); nxt();
    do_lr(1, 32'h2000); run(1);
    do_wr(1, 32'h2000); run(1);
    @(negedge clk); check("own_store_keeps", {31'd0, vld64[1]}, 32'd1); nxt();
    do_sc(1, 32'h2000); @(negedge clk);
    check("own_store_sc_ok", {31'd0, gnt64}, 32'd1); nxt();

    // LR racing a foreign store to the same granule ends valid
    do_lr(0, 32'h3000); do_wr(1, 32'h3000); run(1);
    @(negedge clk); check("lr_after_store", {31'd0, vld64[0]}, 32'd1); nxt();
    do_wr(1, 32'h3004); run(1);
    @(negedge clk); check("store_other_gran", {31'd0, vld64[0]}, 32'd1); nxt();
    do_wr(1, 32'h3001); run(1);
    @(negedge clk); check("store_kills", {31'd0, vld64[0]}, 32'd0); nxt();

    // Address zero reservation; clear beats a same-cycle LR
    do_lr(0, 32'h0); run(1);
    do_sc(0, 32'h0); @(negedge clk);
    check("sc_addr0", {31'd0, gnt64}, 32'd1); nxt();
    do_lr(0, 32'h0); i_clr_en = 1; i_clr_id = 0; run(1);
    @(negedge clk); check("clr_beats_lr", {31'd0, vld64[0]}, 32'd0); nxt();

    // Lifetime 4: SC in cycle 4 succeeds, in cycle 5 fails
    do_lr(0, 32'h40); run(1);
    run(3);
    do_sc(0, 32'h40); @(negedge clk);
    check("to4_sc_c4", {31'd0, gnt4}, 32'd1); nxt();
    do_lr(0, 32'h40); run(1);
    run(3);
    @(negedge clk); check("to4_vld_c4", {31'd0, vld4[0]}, 32'd1); nxt();
    do_sc(0, 32'h40); @(negedge clk);
    check("to4_vld_c5", {31'd0, vld4[0]}, 32'd0);
    check("to4_sc_c5", {31'd0, gnt4}, 32'd0);
    check("to64_sc_c5", {31'd0, gnt64}, 32'd1); nxt();

    // Mixed traffic over a small address pool, checked by the model each cycle
    for (int i = 0; i < 400; i++) begin
      i_lr      = ($urandom_range(0, 3) == 0);
      i_sc      = ($urandom_range(0, 2) == 0);
      i_id      = 1'($urandom_range(0, 1));
      i_addr    = pool[$urandom_range(0, 3)];
      i_wr_en   = ($urandom_range(0, 3) == 0);
      i_wr_id   = 1'($urandom_range(0, 1));
      i_wr_addr = pool[$urandom_range(0, 3)];
      i_clr_en  = ($urandom_range(0, 15) == 0);
      i_clr_id  = 1'($urandom_range(0, 1));
      @(negedge clk); nxt();
    end

    // Asynchronous reset mid-cycle discards live reservations
    do_lr(0, 32'h10); run(1);
    do_lr(1, 32'h20); run(1);
    @(negedge clk); check("pre_reset_vld", {30'd0, vld64}, 32'd3);
    #2; do_sc(0, 32'h10); i_rst = 0;
    #1;
    check("async_rst_vld64", {30'd0, vld64}, 32'd0);
    check("async_rst_vld4", {30'd0, vld4}, 32'd0);
    check("async_rst_gnt", {31'd0, gnt64}, 32'd0);
    @(posedge clk); #3; i_rst = 1;
    @(negedge clk); check("post_reset_sc", {31'd0, gnt64}, 32'd0); nxt();
    run(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lr_sc_resv_unit.md
LR_SC_RESV_UNIT -- requirements
Module: lr_sc_resv_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default `XLEN, address width in bits.
REQ-002 SHALL have parameter N_IDS, default 2, number of reservation entries (one per hart/ID), N_IDS >= 2.
REQ-003 SHALL have parameter GRANULE_LOG2, default 2, log2 of reservation granule in bytes; address bits [GRANULE_LOG2-1:0] ignored in all compares.
REQ-004 SHALL have parameter TIMEOUT, default 64, reservation lifetime in cycles; 0 disables expiry.
REQ-005 i_clk  in  1  clock; all state updates on rising edge.
REQ-006 i_rst  in  1  reset, asynchronous, active-low.
REQ-007 i_lr  in  1  load-reserved request: set reservation for i_id at i_addr.
REQ-008 i_sc  in  1  store-conditional request: check reservation for i_id at i_addr.
REQ-009 i_id  in  $clog2(N_IDS)  requester of i_lr/i_sc.
REQ-010 i_addr  in  ADDR_WIDTH  address of i_lr/i_sc.
REQ-011 i_wr_en  in  1  snooped store committed by any agent.
REQ-012 i_wr_id  in  $clog2(N_IDS)  ID of snooped store.
REQ-013 i_wr_addr  in  ADDR_WIDTH  address of snooped store.
REQ-014 i_clr_en  in  1  clear entry i_clr_id (trap, context switch).
REQ-015 i_clr_id  in  $clog2(N_IDS)  entry to clear.
REQ-016 o_gnt  out  1  SC success, combinational, meaningful only while i_sc=1, 0 otherwise.
REQ-017 o_resv_vld  out  N_IDS  registered valid bit per entry.

Function
REQ-018 Each entry SHALL hold valid bit, granule address (ADDR_WIDTH-GRANULE_LOG2 bits), down-counter of width $clog2(TIMEOUT+1) (min 1).
REQ-019 Entry k "hits" address A SHALL mean valid[k]=1 and stored granule == A[ADDR_WIDTH-1:GRANULE_LOG2]; address 0 is a legal reservation.
REQ-020 o_gnt SHALL be 1 iff i_sc=1, i_lr=0, entry i_id hits i_addr, and no same-cycle i_wr_en with i_wr_id != i_id hits the same granule (snooped store ordered first).
REQ-021 i_lr SHALL load entry i_id: valid=1, granule=i_addr granule, counter=TIMEOUT; takes effect next edge, regardless of prior state.
REQ-022 i_lr and i_sc together SHALL perform the LR only; o_gnt=0.
REQ-023 Any i_sc (success or fail) SHALL clear valid[i_id] at next edge.
REQ-024 Successful SC SHALL also clear every other entry hitting i_addr granule.
REQ-025 i_wr_en SHALL clear every entry k != i_wr_id hitting i_wr_addr granule; entry i_wr_id unaffected by its own store.
REQ-026 LR and snooped store from another ID to the same granule in one cycle: store ordered first, entry i_id SHALL end valid.
REQ-027 i_clr_en SHALL clear entry i_clr_id; clear beats same-cycle LR to that entry.
REQ-028 TIMEOUT>0: counter of valid entry SHALL decrement each cycle; edge at which it goes 1->0 SHALL clear valid; SC in that last cycle (counter=1) still succeeds.
REQ-029 TIMEOUT=0: counters held 0, no expiry.
REQ-030 Cleared entries SHALL keep counter at 0; stored granule value irrelevant when invalid.
REQ-031 Multiple independent clears in one cycle SHALL all apply; no request is ever stalled (no back-pressure).

Reset
REQ-032 i_rst=0 SHALL asynchronously set all valid=0, counters=0, granules=0; o_resv_vld=0, o_gnt=0.
REQ-033 First edge after i_rst deasserts SHALL process requests normally; reset during a pending reservation discards it.

Verification
REQ-034 N_IDS=2, TIMEOUT=64: LR id0 @0x1000, 5 cycles, SC id0 @0x1003 -> o_gnt=1 (same granule), o_resv_vld=2'b00 next cycle.
REQ-035 LR id0 @0x1000 and LR id1 @0x1000; SC id1 succeeds -> next cycle SC id0 @0x1000 -> o_gnt=0.
REQ-036 LR id1 @0x2000; i_wr_en id0 @0x2002 same cycle as SC id1 @0x2000 -> o_gnt=0; store id1 @0x2000 alone leaves entry 1 valid.
REQ-037 TIMEOUT=4: LR id0 @0x40 at cycle 0; SC at cycle 4 -> o_gnt=1; repeat with SC at cycle 5 -> o_gnt=0, o_resv_vld[0] dropped at edge ending cycle 4.
REQ-038 LR id0 @0x0 -> SC id0 @0x0 -> o_gnt=1; i_clr_en id0 with same-cycle LR id0 -> o_resv_vld[0]=0.
REQ-039 Assert i_rst=0 mid-cycle with entries valid -> o_resv_vld=0 immediately, before next edge; SC after release -> o_gnt=0.
